// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the instruction/data SRAM-bus arbiter: FSM states,
// owner encoding and transfer size codes.
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Serialises instruction-fetch and data accesses onto one sram-like memory
// port, one transaction in flight, alternating priority on simultaneous requests.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_data_ok,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_ok
);

  state_t            state, state_nxt;
  owner_t            owner, last_owner;
  logic              lat_wr;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic grant_inst, grant_data, complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_INST;
      last_owner <= OWN_INST;
      lat_wr     <= 1'b0;
      lat_size   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_inst) begin
        owner     <= OWN_INST;
        lat_wr    <= 1'b0;
        lat_size  <= SIZE_W;
        lat_addr  <= inst_addr;
        lat_wdata <= '0;
      end else if (grant_data) begin
        owner     <= OWN_DATA;
        lat_wr    <= data_wr;
        lat_size  <= data_size;
        lat_addr  <= data_addr;
        lat_wdata <= data_wdata;
      end
      if (complete) begin
        last_owner <= owner;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_inst   = 1'b0;
    grant_data   = 1'b0;
    complete     = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state)
      IDLE: begin
        // Gated by rst so the grant pulse cannot leak out while reset is held.
        if (!rst) begin
          if (inst_req && data_req) begin
            grant_data = (last_owner == OWN_INST);
            grant_inst = (last_owner == OWN_DATA);
          end else begin
            grant_inst = inst_req;
            grant_data = data_req;
          end
        end
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        if (grant_inst || grant_data) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        mem_req   = 1'b1;
        mem_wr    = lat_wr;
        mem_size  = lat_size;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (mem_addr_ok && mem_data_ok) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (mem_addr_ok) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Response is routed to the owner only, and only in the completion cycle.
    if (complete) begin
      if (owner == OWN_INST) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_rdata;
      end else begin
        data_data_ok = 1'b1;
        data_rdata   = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed-vector bench for sram_bus_arbiter: a per-cycle stimulus/expectation
// table plus hand-written reset-abort sequences.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic [31:0] mem_rdata;
  logic        mem_data_ok;

  int n_vec = 0;
  int n_bad = 0;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_rdata(mem_rdata),
    .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [1:0]  dsize;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        maok;
    logic        mdok;
    logic [31:0] mrdata;
    logic        e_iaok;
    logic        e_idok;
    logic [31:0] e_irdata;
    logic        e_daok;
    logic        e_ddok;
    logic [31:0] e_drdata;
    logic        e_mreq;
    logic        e_mwr;
    logic [1:0]  e_msize;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    n_vec++;
    chk({tag, " inst_addr_ok"}, 32'(inst_addr_ok), 32'(v.e_iaok));
    chk({tag, " inst_data_ok"}, 32'(inst_data_ok), 32'(v.e_idok));
    chk({tag, " inst_rdata"},   inst_rdata,         v.e_irdata);
    chk({tag, " data_addr_ok"}, 32'(data_addr_ok), 32'(v.e_daok));
    chk({tag, " data_data_ok"}, 32'(data_data_ok), 32'(v.e_ddok));
    chk({tag, " data_rdata"},   data_rdata,         v.e_drdata);
    chk({tag, " mem_req"},      32'(mem_req),      32'(v.e_mreq));
    chk({tag, " mem_wr"},       32'(mem_wr),       32'(v.e_mwr));
    chk({tag, " mem_size"},     32'(mem_size),     32'(v.e_msize));
    chk({tag, " mem_addr"},     mem_addr,           v.e_maddr);
    chk({tag, " mem_wdata"},    mem_wdata,          v.e_mwdata);
  endtask

  task automatic drive(input vec_t v);
    inst_req    = v.ireq;
    inst_addr   = v.iaddr;
    data_req    = v.dreq;
    data_wr     = v.dwr;
    data_size   = v.dsize;
    data_addr   = v.daddr;
    data_wdata  = v.dwdata;
    mem_addr_ok = v.maok;
    mem_data_ok = v.mdok;
    mem_rdata   = v.mrdata;
  endtask

  vec_t zero_v, ev;

  initial begin
    zero_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    //          ireq iaddr         dreq wr sz daddr wdata maok mdok mrdata      | iaok idok irdata       daok ddok drdata mreq wr sz maddr         mwdata
    vecs[0]  = '{0, 32'h0,        0, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 32'hBFC00000, 0, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    vecs[2]  = '{0, 32'h0,        0, 0, 0, 32'h0,  32'h0, 1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 2, 32'hBFC00000, 32'h0};
    vecs[3]  = '{0, 32'h0,        0, 0, 0, 32'h0,  32'h0, 0, 1, 32'h20020005,  0, 1, 32'h20020005, 0, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    // Both requesters held: data wins the first tie, then strict alternation.
    vecs[4]  = '{1, 32'h100,      1, 1, 2, 32'd84, 32'd7, 0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    vecs[5]  = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 2, 32'd84,       32'd7};
    vecs[6]  = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 0, 1, 32'h11,        0, 0, 32'h0,        0, 1, 32'h11, 0, 0, 0, 32'h0,        32'h0};
    vecs[7]  = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 0, 0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    vecs[8]  = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 2, 32'h100,      32'h0};
    vecs[9]  = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 0, 1, 32'h22,        0, 1, 32'h22,       0, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    vecs[10] = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    vecs[11] = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 2, 32'h88,       32'h0};
    vecs[12] = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 0, 1, 32'h33,        0, 0, 32'h0,        0, 1, 32'h33, 0, 0, 0, 32'h0,        32'h0};
    vecs[13] = '{1, 32'h100,      1, 0, 2, 32'h88, 32'h0, 0, 0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    // Slow memory: addr_ok after 3 stalled cycles, data_ok 4 cycles later.
    vecs[14] = '{0, 32'h0,        1, 0, 0, 32'h50, 32'h0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 2, 32'h100,      32'h0};
    vecs[15] = vecs[14];
    vecs[16] = vecs[14];
    vecs[17] = '{0, 32'h0,        1, 0, 0, 32'h50, 32'h0, 1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 2, 32'h100,      32'h0};
    vecs[18] = '{0, 32'h0,        1, 0, 0, 32'h50, 32'h0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    vecs[19] = vecs[18];
    vecs[20] = vecs[18];
    vecs[21] = '{0, 32'h0,        1, 0, 0, 32'h50, 32'h0, 0, 1, 32'h44,        0, 1, 32'h44,       0, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    // Byte load with addr_ok and data_ok in the same ADDR cycle.
    vecs[22] = '{0, 32'h0,        1, 0, 0, 32'h50, 32'h0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0,  0, 0, 0, 32'h0,        32'h0};
    vecs[23] = '{0, 32'h0,        0, 0, 0, 32'h0,  32'h0, 1, 1, 32'hFF,        0, 0, 32'h0,        0, 1, 32'hFF, 1, 0, 0, 32'h50,       32'h0};
    vecs[24] = zero_v;

    rst = 1'b1;
    drive(zero_v);
    inst_req = 1'b1;
    data_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset_held", zero_v);
    rst = 1'b0;
    drive(zero_v);
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), vecs[i]);
      @(posedge clk); #1;
    end

    // Reset while in ADDR: mem_req must drop without waiting for a clock.
    ev = zero_v; ev.ireq = 1; ev.iaddr = 32'h300;
    drive(ev);
    @(negedge clk);
    ev.e_iaok = 1; chk_all("abort_addr_grant", ev);
    @(posedge clk); #1;
    drive(zero_v);
    @(negedge clk);
    ev = zero_v; ev.e_mreq = 1; ev.e_msize = 2; ev.e_maddr = 32'h300;
    chk_all("abort_addr_mreq", ev);
    rst = 1'b1;
    #1;
    chk_all("abort_addr_async", zero_v);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset while in WAIT, then a stale data_ok arrives in IDLE.
    ev = zero_v; ev.ireq = 1; ev.iaddr = 32'h400;
    drive(ev);
    @(negedge clk);
    ev.e_iaok = 1; chk_all("abort_wait_grant", ev);
    @(posedge clk); #1;
    ev = zero_v; ev.maok = 1;
    drive(ev);
    @(posedge clk); #1;
    ev = zero_v; ev.ireq = 1; ev.iaddr = 32'h500; ev.dreq = 1; ev.dsize = 2; ev.daddr = 32'h600;
    drive(ev);
    @(negedge clk);
    chk_all("wait_no_accept", zero_v);
    rst = 1'b1;
    #1;
    chk_all("wait_rst_async", zero_v);
    @(posedge clk); #1;
    chk_all("wait_rst_held", zero_v);
    @(negedge clk);
    rst = 1'b0;
    drive(zero_v);
    @(posedge clk); #1;
    ev = zero_v; ev.mdok = 1; ev.mrdata = 32'hDEAD;
    drive(ev);
    @(negedge clk);
    chk_all("stale_data_ok", zero_v);
    @(posedge clk); #1;

    // After reset the tie goes to data again, and the service is normal.
    ev = zero_v; ev.ireq = 1; ev.iaddr = 32'h500; ev.dreq = 1; ev.dsize = 2; ev.daddr = 32'h600;
    drive(ev);
    @(negedge clk);
    ev.e_daok = 1; chk_all("post_rst_tie", ev);
    @(posedge clk); #1;
    ev = zero_v; ev.ireq = 1; ev.iaddr = 32'h500; ev.maok = 1; ev.mdok = 1; ev.mrdata = 32'hABCD;
    drive(ev);
    @(negedge clk);
    ev.e_ddok = 1; ev.e_drdata = 32'hABCD; ev.e_mreq = 1; ev.e_msize = 2; ev.e_maddr = 32'h600;
    chk_all("post_rst_xfer", ev);
    @(posedge clk); #1;
    ev = zero_v; ev.ireq = 1; ev.iaddr = 32'h500;
    drive(ev);
    @(negedge clk);
    ev.e_iaok = 1; chk_all("post_rst_inst_turn", ev);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
